// File: rtl/cmutex_merge_n_cache.sv
// N-channel mutex merge with a single-entry output buffer for the cache control path.
// Build option: define CMERGE_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module cmutex_merge_n_cache #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 2,
    localparam int ID_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          i_drive,
    input  logic [N_CH*DATA_W-1:0]   i_data,
    output logic [N_CH-1:0]          o_free,
    output logic                     o_driveNext,
    output logic [DATA_W-1:0]        o_data,
    output logic [ID_W-1:0]          o_id,
    input  logic                     i_freeNext
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state, state_nx;

    logic                any_drive;
    logic                cap;
    logic [ID_W-1:0]     win;
    logic [N_CH-1:0]     grant;
    logic [DATA_W-1:0]   cap_data;
    logic [DATA_W-1:0]   data_p1;
    logic [ID_W-1:0]     id_p1;

    // Index addition modulo N_CH; operands are always < N_CH.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a,
                                                 input logic [ID_W-1:0] b);
        logic [ID_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (ID_W+1)'(N_CH))
            s = s - (ID_W+1)'(N_CH);
        return s[ID_W-1:0];
    endfunction

    function automatic logic [ID_W-1:0] first_set(input logic [N_CH-1:0] v);
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (v[i])
                r = ID_W'(i);
        end
        return r;
    endfunction

    assign any_drive = |i_drive;

`ifdef CMERGE_RR_EN
    logic [ID_W-1:0]     ptr_p1;
    logic [2*N_CH-1:0]   drive_dbl;
    logic [N_CH-1:0]     drive_rot;

    // Rotate requests so the pointer channel sits at bit 0, then map the offset back.
    assign drive_dbl = {i_drive, i_drive} >> ptr_p1;
    assign drive_rot = drive_dbl[N_CH-1:0];
    assign win       = wrap_add(ptr_p1, first_set(drive_rot));

    always_ff @(posedge clk) begin
        if (rst)
            ptr_p1 <= '0;
        else if (cap)
            ptr_p1 <= wrap_add(win, ID_W'(1));
    end
`else
    assign win = first_set(i_drive);
`endif

    assign cap    = any_drive & ~rst & ((state == EMPTY) | i_freeNext);
    assign grant  = N_CH'(1) << win;
    assign o_free = cap ? grant : '0;

    always_comb begin
        cap_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (win == ID_W'(i))
                cap_data = i_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            EMPTY: if (any_drive) state_nx = FULL;
            FULL:  if (i_freeNext && !any_drive) state_nx = EMPTY;
            default: state_nx = EMPTY;
        endcase
    end

    // Stage p1: output buffer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            data_p1 <= '0;
            id_p1   <= '0;
        end else begin
            state <= state_nx;
            if (cap) begin
                data_p1 <= cap_data;
                id_p1   <= win;
            end else if (state == FULL && i_freeNext) begin
                data_p1 <= '0;
            end
        end
    end

    assign o_driveNext = (state == FULL);
    assign o_data      = data_p1;
    assign o_id        = id_p1;

endmodule
